// File: rtl/scoreboard_if.sv
// Shared issue/commit record types and the scoreboard's bundled port interface.
// The package has to be compiled ahead of the interface and the scoreboard that use it.
package ariane_pkg;

    typedef enum logic [3:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR,
        FPU
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0] pc;
        fu_t         fu;
        logic [7:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] result;
        logic        valid;
        logic        use_imm;
        exception_t  ex;
    } scoreboard_entry;

endpackage

interface scoreboard_if #(
    parameter int unsigned NR_ENTRIES = 8
);
    localparam int unsigned TW = $clog2(NR_ENTRIES);

    ariane_pkg::scoreboard_entry decoded_instr_i;
    logic                        decoded_instr_valid_i;
    logic                        decoded_instr_ack_o;
    logic [TW-1:0]               issue_trans_id_o;
    logic                        full_o;

    logic [4:0]                  rs1_i;
    logic [4:0]                  rs2_i;
    logic                        rs1_busy_o;
    logic                        rs2_busy_o;
    logic                        rs1_fwd_valid_o;
    logic                        rs2_fwd_valid_o;
    logic [63:0]                 rs1_o;
    logic [63:0]                 rs2_o;

    logic                        wb_valid_i;
    logic [TW-1:0]               wb_trans_id_i;
    logic [63:0]                 wb_data_i;
    ariane_pkg::exception_t      wb_ex_i;

    ariane_pkg::scoreboard_entry commit_instr_o;
    logic                        commit_valid_o;
    logic                        commit_ack_i;

    modport slave (
        input  decoded_instr_i, decoded_instr_valid_i, rs1_i, rs2_i,
               wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i, commit_ack_i,
        output decoded_instr_ack_o, issue_trans_id_o, full_o,
               rs1_busy_o, rs2_busy_o, rs1_fwd_valid_o, rs2_fwd_valid_o, rs1_o, rs2_o,
               commit_instr_o, commit_valid_o
    );

    modport master (
        output decoded_instr_i, decoded_instr_valid_i, rs1_i, rs2_i,
               wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i, commit_ack_i,
        input  decoded_instr_ack_o, issue_trans_id_o, full_o,
               rs1_busy_o, rs2_busy_o, rs1_fwd_valid_o, rs2_fwd_valid_o, rs1_o, rs2_o,
               commit_instr_o, commit_valid_o
    );

endinterface

// File: rtl/scoreboard.sv
// In-order circular buffer between issue and commit: tracks in-flight instructions,
// collects FU results by transaction id and answers operand hazard/forwarding lookups.
module scoreboard
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    scoreboard_if.slave    sb
);

    localparam int unsigned TW       = $clog2(NR_ENTRIES);
    localparam logic [TW:0] FULL_CNT = NR_ENTRIES[TW:0];
    localparam logic [TW-1:0] PTR_ONE = TW'(1);
    localparam logic [TW:0]   CNT_ONE = (TW+1)'(1);

    typedef struct packed {
        logic        busy;
        logic        fwd;
        logic [63:0] data;
    } lookup_t;

    scoreboard_entry [NR_ENTRIES-1:0] mem_q, mem_d;
    logic [NR_ENTRIES-1:0]            occupied_q, occupied_d;
    logic [TW-1:0]                    head_q, head_d;
    logic [TW-1:0]                    tail_q, tail_d;
    logic [TW:0]                      count_q, count_d;

    logic    full_s;
    logic    issue_fire_s;
    logic    wb_fire_s;
    logic    commit_valid_s;
    logic    commit_fire_s;
    lookup_t rs1_look_s;
    lookup_t rs2_look_s;

    // Walk oldest to youngest so the last hit is the youngest in-flight writer.
    function automatic lookup_t lookup(
        input logic [4:0]                       rs,
        input scoreboard_entry [NR_ENTRIES-1:0] mem,
        input logic [NR_ENTRIES-1:0]            occ,
        input logic [TW-1:0]                    head
    );
        lookup_t       res;
        logic [TW-1:0] idx;
        logic          hit;
        res = '0;
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            idx      = head + i[TW-1:0];
            hit      = occ[idx] && (mem[idx].rd == rs) && (rs != 5'd0);
            res.busy = hit ? ~mem[idx].valid : res.busy;
            res.fwd  = hit ? mem[idx].valid : res.fwd;
            res.data = hit ? (mem[idx].valid ? mem[idx].result : 64'd0) : res.data;
        end
        return res;
    endfunction

    // Handshake qualifiers; full comes from the registered count only.
    always_comb begin
        full_s         = (count_q == FULL_CNT);
        commit_valid_s = occupied_q[head_q] & mem_q[head_q].valid;
        issue_fire_s   = sb.decoded_instr_valid_i & ~full_s & ~flush_i;
        wb_fire_s      = sb.wb_valid_i & occupied_q[sb.wb_trans_id_i] & ~flush_i;
        commit_fire_s  = sb.commit_ack_i & commit_valid_s & ~flush_i;
    end

    // Operand lookups and externally visible status, all from registered state.
    always_comb begin
        rs1_look_s             = lookup(sb.rs1_i, mem_q, occupied_q, head_q);
        rs2_look_s             = lookup(sb.rs2_i, mem_q, occupied_q, head_q);
        sb.rs1_busy_o          = rs1_look_s.busy;
        sb.rs1_fwd_valid_o     = rs1_look_s.fwd;
        sb.rs1_o               = rs1_look_s.data;
        sb.rs2_busy_o          = rs2_look_s.busy;
        sb.rs2_fwd_valid_o     = rs2_look_s.fwd;
        sb.rs2_o               = rs2_look_s.data;
        sb.decoded_instr_ack_o = issue_fire_s;
        sb.issue_trans_id_o    = tail_q;
        sb.full_o              = full_s;
        sb.commit_instr_o      = mem_q[head_q];
        sb.commit_valid_o      = commit_valid_s;
    end

    // Next-state: flush overrides everything, otherwise writeback, commit and issue.
    always_comb begin
        mem_d      = mem_q;
        occupied_d = occupied_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (flush_i) begin
            occupied_d = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (wb_fire_s) begin
                mem_d[sb.wb_trans_id_i].result = sb.wb_data_i;
                mem_d[sb.wb_trans_id_i].valid  = 1'b1;
                mem_d[sb.wb_trans_id_i].ex     = sb.wb_ex_i.valid ? sb.wb_ex_i
                                                                  : mem_q[sb.wb_trans_id_i].ex;
            end else begin
                mem_d = mem_q;
            end

            if (commit_fire_s) begin
                occupied_d[head_q] = 1'b0;
                head_d             = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end

            // Issue slot is never occupied when not full, so it cannot collide with wb/commit.
            if (issue_fire_s) begin
                mem_d[tail_q]        = sb.decoded_instr_i;
                mem_d[tail_q].valid  = sb.decoded_instr_i.ex.valid |
                                       (sb.decoded_instr_i.fu == NONE);
                mem_d[tail_q].result = 64'd0;
                occupied_d[tail_q]   = 1'b1;
                tail_d               = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end

            case ({issue_fire_s, commit_fire_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q      <= '0;
            occupied_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            mem_q      <= mem_d;
            occupied_q <= occupied_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard: issue pushes the expected commit record into a queue
// and an independent monitor pops and compares it whenever the DUT retires an entry.
module tb_scoreboard;
    import ariane_pkg::*;

    localparam int unsigned N  = 8;
    localparam int unsigned TW = $clog2(N);

    typedef struct {
        logic [63:0] pc;
        logic [63:0] res;
        logic        exv;
        logic [63:0] cause;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    scoreboard_if #(.NR_ENTRIES(N)) bus ();

    scoreboard #(.NR_ENTRIES(N)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .sb      (bus.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Commit monitor: every retirement must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.commit_valid_o && bus.commit_ack_i) begin
            if (exp_q.size() == 0) begin
                chk("commit_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("commit_pc", bus.commit_instr_o.pc, mon_e.pc);
                chk("commit_result", bus.commit_instr_o.result, mon_e.res);
                chk("commit_ex_valid", {63'd0, bus.commit_instr_o.ex.valid}, {63'd0, mon_e.exv});
                chk("commit_ex_cause", bus.commit_instr_o.ex.cause, mon_e.cause);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.decoded_instr_valid_i = 1'b0;
        bus.wb_valid_i            = 1'b0;
        bus.commit_ack_i          = 1'b0;
        flush                     = 1'b0;
    endtask

    // Present one decoded entry; result/valid fields carry junk the DUT must override.
    task automatic iss(input logic [63:0] pc, input logic [4:0] rd, input fu_t fu,
                       input logic dexv, input logic [63:0] dcause, input logic [TW-1:0] id,
                       input logic [63:0] xres, input logic xexv, input logic [63:0] xcause);
        scoreboard_entry e;
        exp_t            x;
        e          = '0;
        e.pc       = pc;
        e.rd       = rd;
        e.fu       = fu;
        e.result   = 64'hDEAD_BEEF;
        e.valid    = 1'b1;
        e.ex.valid = dexv;
        e.ex.cause = dcause;
        bus.decoded_instr_i       = e;
        bus.decoded_instr_valid_i = 1'b1;
        #1;
        chk("issue_ack", {63'd0, bus.decoded_instr_ack_o}, 64'd1);
        chk("issue_trans_id", {{(64-TW){1'b0}}, bus.issue_trans_id_o}, {{(64-TW){1'b0}}, id});
        x.pc = pc; x.res = xres; x.exv = xexv; x.cause = xcause;
        exp_q.push_back(x);
    endtask

    task automatic wb(input logic [TW-1:0] id, input logic [63:0] data,
                      input logic exv, input logic [63:0] cause);
        bus.wb_valid_i       = 1'b1;
        bus.wb_trans_id_i    = id;
        bus.wb_data_i        = data;
        bus.wb_ex_i          = '0;
        bus.wb_ex_i.valid    = exv;
        bus.wb_ex_i.cause    = cause;
    endtask

    initial begin
        rst_n = 1'b1;
        flush = 1'b0;
        bus.decoded_instr_i       = '0;
        bus.decoded_instr_valid_i = 1'b0;
        bus.rs1_i                 = 5'd0;
        bus.rs2_i                 = 5'd0;
        bus.wb_valid_i            = 1'b0;
        bus.wb_trans_id_i         = '0;
        bus.wb_data_i             = 64'd0;
        bus.wb_ex_i               = '0;
        bus.commit_ack_i          = 1'b0;

        // Reset values, including combinational ack while held in reset.
        #2 rst_n = 1'b0;
        #1;
        bus.rs1_i = 5'd5;
        bus.decoded_instr_valid_i = 1'b1;
        #1;
        chk("rst_ack", {63'd0, bus.decoded_instr_ack_o}, 64'd1);
        chk("rst_trans_id", {{(64-TW){1'b0}}, bus.issue_trans_id_o}, 64'd0);
        chk("rst_full", {63'd0, bus.full_o}, 64'd0);
        chk("rst_commit_valid", {63'd0, bus.commit_valid_o}, 64'd0);
        chk("rst_commit_pc", bus.commit_instr_o.pc, 64'd0);
        chk("rst_rs1_busy", {63'd0, bus.rs1_busy_o}, 64'd0);
        chk("rst_rs1_fwd", {63'd0, bus.rs1_fwd_valid_o}, 64'd0);
        bus.decoded_instr_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Single ALU op: busy, then forwarded, then committed.
        iss(64'h100, 5'd5, ALU, 1'b0, 64'd0, TW'(0), 64'h2A, 1'b0, 64'd0);
        cyc();
        bus.rs1_i = 5'd5;
        #1;
        chk("a_busy", {63'd0, bus.rs1_busy_o}, 64'd1);
        chk("a_fwd_pending", {63'd0, bus.rs1_fwd_valid_o}, 64'd0);
        wb(TW'(0), 64'h2A, 1'b0, 64'd0);
        #1;
        chk("a_no_bypass", {63'd0, bus.rs1_fwd_valid_o}, 64'd0);
        chk("a_commit_pre_wb", {63'd0, bus.commit_valid_o}, 64'd0);
        cyc();
        #1;
        chk("a_fwd", {63'd0, bus.rs1_fwd_valid_o}, 64'd1);
        chk("a_fwd_data", bus.rs1_o, 64'h2A);
        chk("a_busy_clear", {63'd0, bus.rs1_busy_o}, 64'd0);
        chk("a_commit_valid", {63'd0, bus.commit_valid_o}, 64'd1);
        bus.commit_ack_i = 1'b1;
        cyc();
        #1;
        chk("a_empty_commit", {63'd0, bus.commit_valid_o}, 64'd0);
        chk("a_empty_lookup", {63'd0, bus.rs1_fwd_valid_o | bus.rs1_busy_o}, 64'd0);

        // Fill to capacity starting at slot 1 so the tail wraps through 0.
        for (int i = 0; i < 8; i++) begin
            iss(64'h200 + 64'(i), 5'(10 + i), ALU, 1'b0, 64'd0, TW'((1 + i) % N),
                64'h1000 + 64'(i), 1'b0, 64'd0);
            cyc();
        end
        #1;
        chk("b_full", {63'd0, bus.full_o}, 64'd1);
        bus.decoded_instr_valid_i = 1'b1;
        bus.commit_ack_i          = 1'b1;
        #1;
        chk("b_ack_when_full", {63'd0, bus.decoded_instr_ack_o}, 64'd0);
        chk("b_commit_not_ready", {63'd0, bus.commit_valid_o}, 64'd0);
        cyc();
        wb(TW'(1), 64'h1000, 1'b0, 64'd0);
        cyc();
        #1;
        chk("b_head_ready", {63'd0, bus.commit_valid_o}, 64'd1);
        bus.commit_ack_i          = 1'b1;
        bus.decoded_instr_valid_i = 1'b1;
        #1;
        chk("b_no_same_cycle_reuse", {63'd0, bus.decoded_instr_ack_o}, 64'd0);
        cyc();
        #1;
        chk("b_not_full", {63'd0, bus.full_o}, 64'd0);
        iss(64'h208, 5'd20, ALU, 1'b0, 64'd0, TW'(1), 64'h1008, 1'b0, 64'd0);
        cyc();
        #1;
        chk("b_full_again", {63'd0, bus.full_o}, 64'd1);
        for (int k = 1; k <= 8; k++) begin
            wb(TW'((1 + k) % N), 64'h1000 + 64'(k), 1'b0, 64'd0);
            cyc();
        end
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("b_drain_valid", {63'd0, bus.commit_valid_o}, 64'd1);
            bus.commit_ack_i = 1'b1;
            cyc();
        end
        #1;
        chk("b_drained", {63'd0, bus.commit_valid_o | bus.full_o}, 64'd0);

        // Two writers of x3: lookup must follow the youngest one.
        flush = 1'b1;
        cyc();
        #1;
        chk("c_trans_id_after_flush", {{(64-TW){1'b0}}, bus.issue_trans_id_o}, 64'd0);
        iss(64'h300, 5'd3, ALU, 1'b0, 64'd0, TW'(0), 64'h5, 1'b0, 64'd0);
        cyc();
        iss(64'h301, 5'd3, ALU, 1'b0, 64'd0, TW'(1), 64'h7, 1'b0, 64'd0);
        cyc();
        wb(TW'(0), 64'h5, 1'b0, 64'd0);
        cyc();
        bus.rs2_i = 5'd3;
        #1;
        chk("c_youngest_busy", {63'd0, bus.rs2_busy_o}, 64'd1);
        chk("c_no_stale_fwd", {63'd0, bus.rs2_fwd_valid_o}, 64'd0);
        wb(TW'(1), 64'h7, 1'b0, 64'd0);
        cyc();
        #1;
        chk("c_fwd", {63'd0, bus.rs2_fwd_valid_o}, 64'd1);
        chk("c_fwd_data", bus.rs2_o, 64'h7);
        bus.commit_ack_i = 1'b1;
        cyc();
        bus.commit_ack_i = 1'b1;
        cyc();

        // Out-of-order writeback; ex on wb without valid must not replace the stored ex.
        iss(64'h400, 5'd8, ALU, 1'b0, 64'd0, TW'(2), 64'hA0, 1'b0, 64'd0);
        cyc();
        iss(64'h401, 5'd9, ALU, 1'b0, 64'd0, TW'(3), 64'hB0, 1'b0, 64'd0);
        cyc();
        wb(TW'(3), 64'hB0, 1'b0, 64'h9);
        cyc();
        #1;
        chk("d_head_blocked", {63'd0, bus.commit_valid_o}, 64'd0);
        bus.commit_ack_i = 1'b1;
        cyc();
        #1;
        chk("d_ack_ignored", {63'd0, bus.commit_valid_o}, 64'd0);
        wb(TW'(2), 64'hA0, 1'b0, 64'h9);
        bus.commit_ack_i = 1'b1;
        #1;
        chk("d_wb_commit_same_cycle", {63'd0, bus.commit_valid_o}, 64'd0);
        cyc();
        #1;
        chk("d_head_ready", {63'd0, bus.commit_valid_o}, 64'd1);
        bus.commit_ack_i = 1'b1;
        cyc();
        #1;
        chk("d_second_ready", {63'd0, bus.commit_valid_o}, 64'd1);
        bus.commit_ack_i = 1'b1;
        cyc();
        #1;
        chk("d_empty", {63'd0, bus.commit_valid_o}, 64'd0);

        // Decoded exception with no FU is immediately committable; FU exception via wb.
        iss(64'h500, 5'd7, NONE, 1'b1, 64'h3, TW'(4), 64'd0, 1'b1, 64'h3);
        cyc();
        #1;
        chk("e_ex_ready", {63'd0, bus.commit_valid_o}, 64'd1);
        iss(64'h501, 5'd11, ALU, 1'b0, 64'd0, TW'(5), 64'h55, 1'b1, 64'h2);
        cyc();
        wb(TW'(5), 64'h55, 1'b1, 64'h2);
        cyc();
        bus.rs1_i = 5'd11;
        #1;
        chk("e_fwd_data", bus.rs1_o, 64'h55);
        bus.commit_ack_i = 1'b1;
        cyc();
        bus.commit_ack_i = 1'b1;
        cyc();

        // Flush with four entries in flight and issue/wb/commit in the same cycle.
        for (int i = 0; i < 4; i++) begin
            iss(64'h600 + 64'(i), 5'(12 + i), ALU, 1'b0, 64'd0, TW'((6 + i) % N),
                64'd0, 1'b0, 64'd0);
            cyc();
        end
        bus.decoded_instr_valid_i = 1'b1;
        wb(TW'(6), 64'h66, 1'b0, 64'd0);
        bus.commit_ack_i = 1'b1;
        flush = 1'b1;
        #1;
        chk("f_ack_during_flush", {63'd0, bus.decoded_instr_ack_o}, 64'd0);
        exp_q.delete();
        cyc();
        bus.rs1_i = 5'd12;
        #1;
        chk("f_commit_valid", {63'd0, bus.commit_valid_o}, 64'd0);
        chk("f_full", {63'd0, bus.full_o}, 64'd0);
        chk("f_trans_id", {{(64-TW){1'b0}}, bus.issue_trans_id_o}, 64'd0);
        chk("f_lookup_cleared", {63'd0, bus.rs1_busy_o | bus.rs1_fwd_valid_o}, 64'd0);

        // x0 never matches even when a valid writer of rd=0 is in flight.
        iss(64'h700, 5'd0, NONE, 1'b0, 64'd0, TW'(0), 64'd0, 1'b0, 64'd0);
        cyc();
        bus.rs1_i = 5'd0;
        bus.rs2_i = 5'd0;
        #1;
        chk("g_rs0_rs1", {63'd0, bus.rs1_busy_o | bus.rs1_fwd_valid_o}, 64'd0);
        chk("g_rs0_rs2", {63'd0, bus.rs2_busy_o | bus.rs2_fwd_valid_o}, 64'd0);
        chk("g_commit_ready", {63'd0, bus.commit_valid_o}, 64'd1);
        bus.commit_ack_i = 1'b1;
        cyc();
        #1;
        chk("g_final_empty", {63'd0, bus.commit_valid_o}, 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
